// File: rtl/bp_sacc_csr_responder.sv
// bp_sacc_csr_responder
//   Accelerator-side responder for uncached I/O commands. Accepts one
//   uc_rd/uc_wr command at a time, decodes it against a small CSR file and
//   returns exactly one response per command. Exposes the CSRs plus a
//   start/busy/done handshake to the accelerator datapath.
//
// Ports
//   clk_i, reset_n_i          clock, async active-low reset
//   io_cmd_*                  command channel (valid/ready)
//   io_resp_*                 response channel (valid/yumi), fields echo the command
//   csr_o                     flattened CSRs, csr k at [64k +: 64] (k<2 reads as 0)
//   start_o                   one-cycle start pulse (write CSR0 bit0)
//   busy_i, done_i            accelerator status inputs
//   err_o                     sticky decode-error flag
//
// FSM states
//   state    | meaning
//   ST_READY | idle, io_cmd_ready_o=1, accepts a command when io_cmd_v_i=1
//   ST_RESP  | response held on io_resp_*, waits for io_resp_yumi_i

module bp_sacc_csr_responder #(
  parameter int paddr_width_p  = 40,
  parameter int lce_id_width_p = 4,
  parameter int csr_els_p      = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        io_cmd_v_i,
  output logic                        io_cmd_ready_o,
  input  logic [3:0]                  io_cmd_type_i,
  input  logic [paddr_width_p-1:0]    io_cmd_addr_i,
  input  logic [2:0]                  io_cmd_size_i,
  input  logic [lce_id_width_p-1:0]   io_cmd_lce_id_i,
  input  logic [63:0]                 io_cmd_data_i,
  output logic                        io_resp_v_o,
  input  logic                        io_resp_yumi_i,
  output logic [3:0]                  io_resp_type_o,
  output logic [paddr_width_p-1:0]    io_resp_addr_o,
  output logic [2:0]                  io_resp_size_o,
  output logic [lce_id_width_p-1:0]   io_resp_lce_id_o,
  output logic [63:0]                 io_resp_data_o,
  output logic [64*csr_els_p-1:0]     csr_o,
  output logic                        start_o,
  input  logic                        busy_i,
  input  logic                        done_i,
  output logic                        err_o
);

  localparam int idx_w_lp = $clog2(csr_els_p);

  typedef enum logic {ST_READY, ST_RESP} state_e;

  state_e                      state_q, state_d;
  logic [3:0]                  resp_type_q, resp_type_d;
  logic [paddr_width_p-1:0]    resp_addr_q, resp_addr_d;
  logic [2:0]                  resp_size_q, resp_size_d;
  logic [lce_id_width_p-1:0]   resp_lce_id_q, resp_lce_id_d;
  logic [63:0]                 resp_data_q, resp_data_d;
  logic [63:0]                 csr_q [csr_els_p];
  logic [63:0]                 csr_d [csr_els_p];
  logic                        start_q, start_d;
  logic                        done_q, done_d;
  logic                        err_q, err_d;

  logic [2:0]          offset;
  logic [1:0]          size_eff;
  logic [idx_w_lp-1:0] idx;
  logic                oor, aligned, is_rd, is_wr, dec_err, accept;
  logic [7:0]          size_bmask, byte_mask;
  logic [63:0]         size_dmask, bit_mask, wdata_sh, rd_raw, rd_data;

  // Command decode, evaluated combinationally against the presented command.
  always_comb begin
    offset   = io_cmd_addr_i[2:0];
    size_eff = (io_cmd_size_i > 3'd3) ? 2'd3 : io_cmd_size_i[1:0];
    idx      = io_cmd_addr_i[3 +: idx_w_lp];
    // Any address bit above the index field means an index past the CSR file.
    oor      = |io_cmd_addr_i[paddr_width_p-1:3+idx_w_lp];
    is_rd    = (io_cmd_type_i == 4'd2);
    is_wr    = (io_cmd_type_i == 4'd3);
    unique case (size_eff)
      2'd0: begin aligned = 1'b1;                size_bmask = 8'h01; size_dmask = 64'h0000_0000_0000_00FF; end
      2'd1: begin aligned = (offset[0] == 1'b0);   size_bmask = 8'h03; size_dmask = 64'h0000_0000_0000_FFFF; end
      2'd2: begin aligned = (offset[1:0] == 2'b0); size_bmask = 8'h0F; size_dmask = 64'h0000_0000_FFFF_FFFF; end
      default: begin aligned = (offset == 3'b0);   size_bmask = 8'hFF; size_dmask = 64'hFFFF_FFFF_FFFF_FFFF; end
    endcase
    dec_err   = !(is_rd || is_wr) || oor || !aligned;
    // Alignment guarantees the shifted byte mask never runs past byte 7.
    byte_mask = size_bmask << offset;
    for (int b = 0; b < 8; b++) begin
      bit_mask[8*b +: 8] = {8{byte_mask[b]}};
    end
    wdata_sh = io_cmd_data_i << {offset, 3'b000};
    if (idx == idx_w_lp'(0)) begin
      rd_raw = {63'b0, busy_i};
    end else if (idx == idx_w_lp'(1)) begin
      rd_raw = {62'b0, busy_i, done_q};
    end else begin
      rd_raw = csr_q[idx];
    end
    rd_data = (rd_raw >> {offset, 3'b000}) & size_dmask;
  end

  assign accept = (state_q == ST_READY) && io_cmd_v_i;

  always_comb begin
    state_d       = state_q;
    resp_type_d   = resp_type_q;
    resp_addr_d   = resp_addr_q;
    resp_size_d   = resp_size_q;
    resp_lce_id_d = resp_lce_id_q;
    resp_data_d   = resp_data_q;
    csr_d         = csr_q;
    start_d       = 1'b0;
    err_d         = err_q;
    done_d        = done_q;
    unique case (state_q)
      ST_READY: begin
        if (io_cmd_v_i) begin
          state_d       = ST_RESP;
          resp_type_d   = io_cmd_type_i;
          resp_addr_d   = io_cmd_addr_i;
          resp_size_d   = io_cmd_size_i;
          resp_lce_id_d = io_cmd_lce_id_i;
          resp_data_d   = (is_rd && !dec_err) ? rd_data : 64'b0;
          if (dec_err) err_d = 1'b1;
          if (is_wr && !dec_err) begin
            // CSR0 is a pure trigger and CSR1 is read-only; only 2.. hold state.
            if (idx >= idx_w_lp'(2)) begin
              csr_d[idx] = (csr_q[idx] & ~bit_mask) | (wdata_sh & bit_mask);
            end
            if (idx == idx_w_lp'(0) && byte_mask[0] && wdata_sh[0]) begin
              start_d = 1'b1;
            end
          end
        end
      end
      default: begin
        if (io_resp_yumi_i) state_d = ST_READY;
      end
    endcase
    if (accept && is_rd && !dec_err && idx == idx_w_lp'(1)) done_d = 1'b0;
    // A done pulse coinciding with the clearing read must not be lost.
    if (done_i) done_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q       <= ST_READY;
      resp_type_q   <= '0;
      resp_addr_q   <= '0;
      resp_size_q   <= '0;
      resp_lce_id_q <= '0;
      resp_data_q   <= '0;
      for (int k = 0; k < csr_els_p; k++) csr_q[k] <= '0;
      start_q       <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      resp_type_q   <= resp_type_d;
      resp_addr_q   <= resp_addr_d;
      resp_size_q   <= resp_size_d;
      resp_lce_id_q <= resp_lce_id_d;
      resp_data_q   <= resp_data_d;
      csr_q         <= csr_d;
      start_q       <= start_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  for (genvar k = 0; k < csr_els_p; k++) begin : g_csr_o
    if (k < 2) begin : g_ctl
      assign csr_o[64*k +: 64] = 64'b0;
    end else begin : g_store
      assign csr_o[64*k +: 64] = csr_q[k];
    end
  end

  assign io_cmd_ready_o   = (state_q == ST_READY);
  assign io_resp_v_o      = (state_q == ST_RESP);
  assign io_resp_type_o   = resp_type_q;
  assign io_resp_addr_o   = resp_addr_q;
  assign io_resp_size_o   = resp_size_q;
  assign io_resp_lce_id_o = resp_lce_id_q;
  assign io_resp_data_o   = resp_data_q;
  assign start_o          = start_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_bp_sacc_csr_responder.sv
// Directed bench for bp_sacc_csr_responder with hand-computed expectations.
module tb_bp_sacc_csr_responder;

  logic         clk_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         io_cmd_v_i = 1'b0;
  logic         io_cmd_ready_o;
  logic [3:0]   io_cmd_type_i = '0;
  logic [39:0]  io_cmd_addr_i = '0;
  logic [2:0]   io_cmd_size_i = '0;
  logic [3:0]   io_cmd_lce_id_i = '0;
  logic [63:0]  io_cmd_data_i = '0;
  logic         io_resp_v_o;
  logic         io_resp_yumi_i = 1'b0;
  logic [3:0]   io_resp_type_o;
  logic [39:0]  io_resp_addr_o;
  logic [2:0]   io_resp_size_o;
  logic [3:0]   io_resp_lce_id_o;
  logic [63:0]  io_resp_data_o;
  logic [511:0] csr_o;
  logic         start_o;
  logic         busy_i = 1'b0;
  logic         done_i = 1'b0;
  logic         err_o;

  bp_sacc_csr_responder #(.paddr_width_p(40), .lce_id_width_p(4), .csr_els_p(8)) dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .io_cmd_type_i(io_cmd_type_i), .io_cmd_addr_i(io_cmd_addr_i),
    .io_cmd_size_i(io_cmd_size_i), .io_cmd_lce_id_i(io_cmd_lce_id_i),
    .io_cmd_data_i(io_cmd_data_i),
    .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .io_resp_type_o(io_resp_type_o), .io_resp_addr_o(io_resp_addr_o),
    .io_resp_size_o(io_resp_size_o), .io_resp_lce_id_o(io_resp_lce_id_o),
    .io_resp_data_o(io_resp_data_o),
    .csr_o(csr_o), .start_o(start_o), .busy_i(busy_i), .done_i(done_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_mis = 0;
  logic [63:0] rd;
  logic        st1, st2;
  logic [3:0]  lce_cnt = 4'h3;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one command from READY and consume its response the next cycle.
  // Called at posedge+1; returns at posedge+1 after the yumi edge.
  task automatic cmd(input logic [3:0] t, input logic [39:0] a, input logic [2:0] s,
                     input logic [63:0] d, output logic [63:0] rdat);
    logic [3:0] lce;
    lce = lce_cnt;
    lce_cnt = lce_cnt + 4'd5;
    check("ready_before_cmd", io_cmd_ready_o, 1);
    io_cmd_v_i = 1'b1; io_cmd_type_i = t; io_cmd_addr_i = a;
    io_cmd_size_i = s; io_cmd_data_i = d; io_cmd_lce_id_i = lce;
    @(posedge clk_i); #1;
    io_cmd_v_i = 1'b0;
    check("resp_v_n1", io_resp_v_o, 1);
    check("resp_type", io_resp_type_o, t);
    check("resp_addr", io_resp_addr_o, a);
    check("resp_size", io_resp_size_o, s);
    check("resp_lce", io_resp_lce_id_o, lce);
    rdat = io_resp_data_o;
    st1 = start_o;
    io_resp_yumi_i = 1'b1;
    @(posedge clk_i); #1;
    io_resp_yumi_i = 1'b0;
    st2 = start_o;
    check("resp_v_after_yumi", io_resp_v_o, 0);
  endtask

  task automatic pulse_reset();
    reset_n_i = 1'b0;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
  endtask

  initial begin
    // 1: reset state, then reset while a response is pending
    repeat (2) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    check("rst_ready", io_cmd_ready_o, 1);
    check("rst_v", io_resp_v_o, 0);
    check("rst_err", err_o, 0);
    check("rst_start", start_o, 0);
    check("rst_resp_data", io_resp_data_o, 0);
    check("rst_resp_addr", io_resp_addr_o, 0);
    cmd(4'd3, 40'h10, 3'd3, 64'h1111, rd);
    check("t1_csr2_pre", csr_o[128 +: 64], 64'h1111);
    io_cmd_v_i = 1'b1; io_cmd_type_i = 4'd0; io_cmd_addr_i = 40'h18; io_cmd_size_i = 3'd3;
    @(posedge clk_i); #1;
    io_cmd_v_i = 1'b0;
    check("t1_pending_v", io_resp_v_o, 1);
    check("t1_pending_err", err_o, 1);
    #2 reset_n_i = 1'b0;
    #1;
    check("t1_inrst_v", io_resp_v_o, 0);
    check("t1_inrst_ready", io_cmd_ready_o, 1);
    check("t1_inrst_err", err_o, 0);
    check("t1_inrst_csr2", csr_o[128 +: 64], 0);
    check("t1_inrst_addr", io_resp_addr_o, 0);
    @(posedge clk_i); #1 reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("t1_post_v", io_resp_v_o, 0);
    check("t1_post_ready", io_cmd_ready_o, 1);
    check("t1_post_csr_all_lo", csr_o[255:0], 0);
    check("t1_post_csr_all_hi", csr_o[511:256], 0);

    // 2: full write then read back
    cmd(4'd3, 40'h10, 3'd3, 64'hDEADBEEF_CAFEF00D, rd);
    check("t2_wr_data", rd, 0);
    cmd(4'd2, 40'h10, 3'd3, 64'h0, rd);
    check("t2_rd_data", rd, 64'hDEADBEEF_CAFEF00D);
    check("t2_csr2", csr_o[128 +: 64], 64'hDEADBEEF_CAFEF00D);

    // 4: start pulse and done/status handling
    check("t4_start_idle", start_o, 0);
    cmd(4'd3, 40'h0, 3'd3, 64'h1, rd);
    check("t4_start_n1", st1, 1);
    check("t4_start_n2", st2, 0);
    check("t4_csr0_out", csr_o[63:0], 0);
    cmd(4'd3, 40'h0, 3'd3, 64'h2, rd);
    check("t4_no_start_bit1", st1, 0);
    cmd(4'd3, 40'h1, 3'd0, 64'h1, rd);
    check("t4_no_start_byte1", st1, 0);
    done_i = 1'b1;
    @(posedge clk_i); #1 done_i = 1'b0;
    cmd(4'd2, 40'h8, 3'd3, 64'h0, rd);
    check("t4_done_rd1", rd, 1);
    cmd(4'd2, 40'h8, 3'd3, 64'h0, rd);
    check("t4_done_rd2", rd, 0);
    busy_i = 1'b1;
    cmd(4'd2, 40'h0, 3'd3, 64'h0, rd);
    check("t4_csr0_busy", rd, 1);
    cmd(4'd2, 40'h8, 3'd3, 64'h0, rd);
    check("t4_csr1_busy", rd, 2);
    busy_i = 1'b0;
    cmd(4'd3, 40'h8, 3'd3, 64'hFF, rd);
    check("t4_csr1_wr_noerr", err_o, 0);
    cmd(4'd2, 40'h8, 3'd3, 64'h0, rd);
    check("t4_csr1_ro", rd, 0);

    // 3: sub-word writes/reads and misalignment
    cmd(4'd3, 40'h10, 3'd3, 64'h0, rd);
    cmd(4'd3, 40'h12, 3'd1, 64'hABCD, rd);
    check("t3_csr2_half", csr_o[128 +: 64], 64'h0000_0000_ABCD_0000);
    cmd(4'd2, 40'h13, 3'd0, 64'h0, rd);
    check("t3_rd_byte", rd, 64'hAB);
    cmd(4'd3, 40'h1C, 3'd2, 64'h11223344, rd);
    check("t3_csr3_word", csr_o[192 +: 64], 64'h11223344_00000000);
    cmd(4'd2, 40'h18, 3'd7, 64'h0, rd);
    check("t3_rd_size7", rd, 64'h11223344_00000000);
    check("t3_err_clean", err_o, 0);
    cmd(4'd2, 40'h11, 3'd1, 64'h0, rd);
    check("t3_misalign_data", rd, 0);
    check("t3_misalign_err", err_o, 1);
    cmd(4'd3, 40'h16, 3'd2, 64'hFFFF_FFFF, rd);
    check("t3_misalign_wr_dropped", csr_o[128 +: 64], 64'h0000_0000_ABCD_0000);
    check("t3_err_sticky", err_o, 1);

    // 5: back-pressure with a second command already valid
    io_cmd_v_i = 1'b1; io_cmd_type_i = 4'd3; io_cmd_addr_i = 40'h20;
    io_cmd_size_i = 3'd3; io_cmd_data_i = 64'h55; io_cmd_lce_id_i = 4'h9;
    @(posedge clk_i); #1;
    io_cmd_type_i = 4'd2; io_cmd_lce_id_i = 4'h2; io_cmd_data_i = 64'h0;
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_ready", io_cmd_ready_o, 0);
      check("t5_hold_v", io_resp_v_o, 1);
      check("t5_hold_type", io_resp_type_o, 3);
      check("t5_hold_lce", io_resp_lce_id_o, 4'h9);
      check("t5_hold_data", io_resp_data_o, 0);
      @(posedge clk_i); #1;
    end
    io_resp_yumi_i = 1'b1;
    check("t5_v_at_yumi", io_resp_v_o, 1);
    @(posedge clk_i); #1;
    io_resp_yumi_i = 1'b0;
    check("t5_ready_after_yumi", io_cmd_ready_o, 1);
    check("t5_no_bypass", io_resp_v_o, 0);
    @(posedge clk_i); #1;
    io_cmd_v_i = 1'b0;
    check("t5_second_v", io_resp_v_o, 1);
    check("t5_second_type", io_resp_type_o, 2);
    check("t5_second_lce", io_resp_lce_id_o, 4'h2);
    check("t5_second_data", io_resp_data_o, 64'h55);
    io_resp_yumi_i = 1'b1;
    @(posedge clk_i); #1 io_resp_yumi_i = 1'b0;
    check("t5_csr4", csr_o[256 +: 64], 64'h55);

    // 6: unsupported type and out-of-range index after a fresh reset
    pulse_reset();
    check("t6_rst_err", err_o, 0);
    check("t6_rst_csr4", csr_o[256 +: 64], 0);
    cmd(4'd3, 40'h10, 3'd3, 64'h1234, rd);
    check("t6_err_clean", err_o, 0);
    cmd(4'd0, 40'h10, 3'd3, 64'hFFFF, rd);
    check("t6_badtype_data", rd, 0);
    check("t6_badtype_err", err_o, 1);
    check("t6_badtype_csr2", csr_o[128 +: 64], 64'h1234);
    cmd(4'd3, 40'h40, 3'd3, 64'h1, rd);
    check("t6_oor_wr_data", rd, 0);
    check("t6_oor_no_start", st1, 0);
    check("t6_oor_csr2", csr_o[128 +: 64], 64'h1234);
    check("t6_oor_csr_hi", csr_o[511:192], 0);
    cmd(4'd2, 40'h50, 3'd3, 64'h0, rd);
    check("t6_oor_rd_data", rd, 0);
    check("t6_err_still", err_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
